palette_ram_arbiter: RTL

- Sequences the single-port palette colour RAM between the video colour-lookup path and the 68000-side CPU port.
- Video lookups own every cycle flagged by ce_pixel. CPU writes are posted into a small FIFO and drained in free cycles. CPU reads are served in free cycles once the FIFO is empty.
- Sits between the bus/priority front end and the external palette RAM. It replaces the fixed CPU/video mux with guaranteed video timing.

---
 rtl/palette_ram_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/palette_ram_arbiter.sv
// palette_ram_arbiter: shares the single-port palette RAM between video colour lookups and the CPU port.
// Ports: clk, RESETn (async active-low reset);
//        ce_pixel/vid_addr -> vid_data/vid_valid: video lookup, result two cycles after its slot;
//        cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_be -> cpu_ack/cpu_rdata: CPU port, writes posted to a FIFO;
//        wq_full: registered FIFO-full flag;
//        ram_addr/ram_dout/ram_wel/ram_weh -> RAM, ram_din <- RAM (one-cycle read latency).
module palette_ram_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 16,
    parameter int WQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              ce_pixel,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_be,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              wq_full,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_din,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_wel,
    output logic              ram_weh
);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WQ_DEPTH);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wq_addr_q [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data_q [WQ_DEPTH];
    logic [1:0]        wq_be_q   [WQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q;
    logic [ADDR_W-1:0] rd_addr_q, last_addr_q;
    logic              vid_p1_q, vid_valid_q;
    logic [DATA_W-1:0] vid_data_q, cpu_rdata_q;
    logic              ack_q, ack_d;
    logic              slot_wr, slot_rd, push, latch_rd;

    // Video always wins; queued writes drain before any read so a read sees every earlier write.
    assign slot_wr = !ce_pixel && count_q != '0;
    assign slot_rd = !ce_pixel && count_q == '0 && state_q == RD_WAIT;

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        push     = 1'b0;
        latch_rd = 1'b0;
        case (state_q)
            IDLE: if (cpu_req) begin
                if (!cpu_we) begin
                    latch_rd = 1'b1;
                    state_d  = RD_WAIT;
                end else if (cpu_be == 2'b00) begin
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (!full_q || slot_wr) begin
                    // a drain this cycle frees the slot the push lands in
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            RD_WAIT: state_d = slot_rd ? RD_DATA : RD_WAIT;
            RD_DATA: begin
                ack_d   = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = cpu_req ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign count_d = (push && !slot_wr) ? count_q + CNT_W'(1) :
                     (slot_wr && !push) ? count_q - CNT_W'(1) : count_q;

    assign ram_addr  = ce_pixel ? vid_addr :
                       slot_wr  ? wq_addr_q[rd_ptr_q] :
                       slot_rd  ? rd_addr_q : last_addr_q;
    assign ram_dout  = slot_wr ? wq_data_q[rd_ptr_q] : '0;
    assign ram_wel   = !(slot_wr && wq_be_q[rd_ptr_q][0]);
    assign ram_weh   = !(slot_wr && wq_be_q[rd_ptr_q][1]);
    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign cpu_ack   = ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign wq_full   = full_q;

    always_ff @(posedge clk) begin
        if (push) begin
            wq_addr_q[wr_ptr_q] <= cpu_addr;
            wq_data_q[wr_ptr_q] <= cpu_wdata;
            wq_be_q[wr_ptr_q]   <= cpu_be;
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            rd_addr_q   <= '0;
            last_addr_q <= '0;
            vid_p1_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_q    <= slot_wr ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            count_q     <= count_d;
            full_q      <= count_d == FULL_CNT;
            rd_addr_q   <= latch_rd ? cpu_addr : rd_addr_q;
            last_addr_q <= ram_addr;
            // RAM data for a slot arrives one cycle later; register it on that cycle
            vid_p1_q    <= ce_pixel;
            vid_valid_q <= vid_p1_q;
            vid_data_q  <= vid_p1_q ? ram_din : vid_data_q;
            cpu_rdata_q <= (state_q == RD_DATA) ? ram_din : cpu_rdata_q;
            ack_q       <= ack_d;
        end
    end
endmodule
